// File: rtl/pv_pkg.sv
// Shared definitions for the player/video blocks: vertical motion states,
// screen geometry and sprite image indices.
package pv_pkg;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2,
    ST_LAND   = 2'd3
  } motion_state_t;

  localparam int SCR_W  = 640;
  localparam int SCR_H  = 480;
  localparam int VBUF_W = 320;
  localparam int VBUF_H = 240;
  localparam int SPR_W  = 78;
  localparam int SPR_H  = 79;
  localparam int NET_X  = 320;

  localparam logic [2:0] ANIM_WALK0 = 3'd0;
  localparam logic [2:0] ANIM_RISE  = 3'd4;
  localparam logic [2:0] ANIM_FALL  = 3'd5;
  localparam logic [2:0] ANIM_LAND  = 3'd6;
  localparam logic [2:0] ANIM_WIN   = 3'd7;

  function automatic logic is_airborne(motion_state_t s);
    return (s == ST_RISE) || (s == ST_FALL);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered falling-edge detector: pulse is high for one clock on the
// cycle after a 1->0 transition of sig is captured.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic pulse
);

  logic sig_q;

  // sig_q starts low so a signal that is already low out of reset is not an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sig_q <= sig;
      pulse <= sig_q & ~sig;
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-player motion controller: once per video frame converts buttons into
// sprite right-edge x, top y and an animation frame index.
module player_motion_ctrl
  import pv_pkg::*;
#(
  parameter int X_MIN    = 155,
  parameter int X_MAX    = 319,
  parameter int X_INIT   = 200,
  parameter int SPEED    = 4,
  parameter int GROUND_Y = 260,
  parameter int JUMP_V0  = 16,
  parameter int GRAVITY  = 1,
  parameter int VMAX     = 16,
  parameter int ANIM_DIV = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       freeze,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       airborne,
  output logic [2:0] anim_frame,
  output logic       frame_tick
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);

  localparam logic [10:0] XMIN_W   = 11'(X_MIN);
  localparam logic [10:0] XMAX_W   = 11'(X_MAX);
  localparam logic [10:0] SPEED_W  = 11'(SPEED);
  localparam logic [10:0] GROUND_W = 11'(GROUND_Y);
  localparam logic [9:0]  XMIN10   = 10'(X_MIN);
  localparam logic [9:0]  XMAX10   = 10'(X_MAX);
  localparam logic [9:0]  XINIT10  = 10'(X_INIT);
  localparam logic [9:0]  GROUND10 = 10'(GROUND_Y);
  localparam logic [5:0]  V0_W     = 6'(JUMP_V0);
  localparam logic [5:0]  GRAV_W   = 6'(GRAVITY);
  localparam logic [5:0]  VMAX_W   = 6'(VMAX);

  logic tick;

  motion_state_t    state, state_nxt;
  logic [5:0]       vy, vy_nxt;
  logic             jump_armed, armed_nxt;
  logic [DIV_W-1:0] walk_cnt, walk_cnt_nxt;
  logic [1:0]       walk_phase, walk_phase_nxt;
  logic [9:0]       pos_x_nxt, pos_y_nxt;
  logic             airborne_nxt;
  logic [2:0]       anim_nxt;
  logic [10:0]      x_ext, y_ext, y_fall;
  logic [6:0]       vy_up;
  logic [5:0]       vy_fall;
  logic             moving;

  edge_detect u_vsync_fall (
    .clk   (clk),
    .reset (reset),
    .sig   (vsync),
    .pulse (tick)
  );

  assign frame_tick = tick;

  // Horizontal step; widened to 11 bits so a left step near zero cannot wrap
  always_comb begin
    x_ext     = {1'b0, pos_x};
    moving    = btn_left ^ btn_right;
    pos_x_nxt = pos_x;
    if (btn_left && !btn_right) begin
      pos_x_nxt = (x_ext < XMIN_W + SPEED_W) ? XMIN10 : 10'(x_ext - SPEED_W);
    end else if (btn_right && !btn_left) begin
      pos_x_nxt = (x_ext + SPEED_W > XMAX_W) ? XMAX10 : 10'(x_ext + SPEED_W);
    end
  end

  // Vertical state machine; a held jump button only re-arms after one release tick
  always_comb begin
    state_nxt = state;
    vy_nxt    = vy;
    pos_y_nxt = pos_y;
    armed_nxt = jump_armed | ~btn_jump;
    y_ext     = {1'b0, pos_y};
    vy_up     = {1'b0, vy} + {1'b0, GRAV_W};
    vy_fall   = (vy_up > {1'b0, VMAX_W}) ? VMAX_W : vy_up[5:0];
    y_fall    = y_ext + {5'b0, vy_fall};
    case (state)
      ST_GROUND: begin
        if (btn_jump && jump_armed) begin
          state_nxt = ST_RISE;
          vy_nxt    = V0_W;
          armed_nxt = 1'b0;
        end
      end
      ST_RISE: begin
        pos_y_nxt = 10'(y_ext - {5'b0, vy});
        if (vy <= GRAV_W) begin
          vy_nxt    = '0;
          state_nxt = ST_FALL;
        end else begin
          vy_nxt = vy - GRAV_W;
        end
      end
      ST_FALL: begin
        if (y_fall >= GROUND_W) begin
          pos_y_nxt = GROUND10;
          vy_nxt    = '0;
          state_nxt = ST_LAND;
        end else begin
          pos_y_nxt = 10'(y_fall);
          vy_nxt    = vy_fall;
        end
      end
      ST_LAND: state_nxt = ST_GROUND;
      default: state_nxt = ST_GROUND;
    endcase
  end

  // Sprite index follows the state being entered; walk cycle only runs on the ground
  always_comb begin
    walk_cnt_nxt   = walk_cnt;
    walk_phase_nxt = walk_phase;
    anim_nxt       = ANIM_WALK0;
    airborne_nxt   = is_airborne(state_nxt);
    case (state_nxt)
      ST_GROUND: begin
        if (moving) begin
          if (walk_cnt == DIV_LAST) begin
            walk_cnt_nxt   = '0;
            walk_phase_nxt = walk_phase + 2'd1;
          end else begin
            walk_cnt_nxt = walk_cnt + DIV_W'(1);
          end
          anim_nxt = {1'b0, walk_phase_nxt};
        end else begin
          walk_cnt_nxt   = '0;
          walk_phase_nxt = '0;
          anim_nxt       = ANIM_WALK0;
        end
      end
      ST_RISE: anim_nxt = ANIM_RISE;
      ST_FALL: anim_nxt = ANIM_FALL;
      ST_LAND: anim_nxt = ANIM_LAND;
      default: anim_nxt = ANIM_WALK0;
    endcase
  end

  // All motion state advances only on an unfrozen frame tick
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_GROUND;
      vy         <= '0;
      jump_armed <= 1'b0;
      walk_cnt   <= '0;
      walk_phase <= '0;
      pos_x      <= XINIT10;
      pos_y      <= GROUND10;
      airborne   <= 1'b0;
      anim_frame <= ANIM_WALK0;
    end else if (tick && !freeze) begin
      state      <= state_nxt;
      vy         <= vy_nxt;
      jump_armed <= armed_nxt;
      walk_cnt   <= walk_cnt_nxt;
      walk_phase <= walk_phase_nxt;
      pos_x      <= pos_x_nxt;
      pos_y      <= pos_y_nxt;
      airborne   <= airborne_nxt;
      anim_frame <= anim_nxt;
    end
  end

endmodule
